// File: rtl/sort4_pkg.sv
// Shared types and helpers for the sorter output drain.
// Build option SORT4_DRAIN_DESC_EN: serialize quads in descending order (maxf first).
package sort4_pkg;

  localparam int SORT4_WIDTH = 32;
  localparam int SORT4_LAT   = 5;
  localparam int SORT4_DEPTH = 2;

  typedef logic [SORT4_WIDTH-1:0] word_t;

  typedef struct packed {
    word_t minf;
    word_t medl;
    word_t medh;
    word_t maxf;
  } quad_t;

  typedef logic [1:0] widx_t;

  // Maps a serializer position to a quad field; position 3 always carries out_last.
  function automatic word_t word_at(input quad_t q, input widx_t idx);
    word_t w;
`ifdef SORT4_DRAIN_DESC_EN
    case (idx)
      2'd0:    w = q.maxf;
      2'd1:    w = q.medh;
      2'd2:    w = q.medl;
      default: w = q.minf;
    endcase
`else
    case (idx)
      2'd0:    w = q.minf;
      2'd1:    w = q.medl;
      2'd2:    w = q.medh;
      default: w = q.maxf;
    endcase
`endif
    return w;
  endfunction

endpackage

// File: rtl/sort4_quad_fifo.sv
// DEPTH-entry quad FIFO; exposes the head and the entry behind it so the
// serializer can roll straight into the next quad on a pop.
module sort4_quad_fifo
  import sort4_pkg::*;
#(
  parameter int DEPTH = SORT4_DEPTH
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  i_push,
  input  quad_t i_wdata,
  input  logic  i_pop,
  output quad_t o_head,
  output quad_t o_next,
  output logic  o_empty,
  output logic  o_has_next,
  output logic  o_full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  quad_t           r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic [CW-1:0]   w_count_nxt;
  logic            r_full;

  always_comb begin
    w_count_nxt = r_count;
    case ({i_push, i_pop})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == FULL_CNT);
    end
  end

  // NOTE: storage has no reset; the pointers alone decide which entries are live,
  // and leaving the array unreset lets it map onto plain RAM/regfile cells.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_head     = r_mem[r_rd_ptr];
  assign o_next     = r_mem[r_rd_ptr + AW'(1)];
  assign o_empty    = (r_count == '0);
  assign o_has_next = (r_count >= CW'(2));
  assign o_full     = r_full;

endmodule

// File: rtl/sort4_drain.sv
// Sorter output collector: tag line marks valid quads, a quad FIFO absorbs them,
// and a registered serializer streams one word per cycle on valid/ready.
module sort4_drain
  import sort4_pkg::*;
#(
  parameter int width = SORT4_WIDTH,
  parameter int LAT   = SORT4_LAT,
  parameter int DEPTH = SORT4_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [width-1:0] maxf,
  input  logic [width-1:0] medh,
  input  logic [width-1:0] medl,
  input  logic [width-1:0] minf,
  output logic [width-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             full,
  output logic             drop,
  output logic [7:0]       drop_cnt
);

  logic [LAT-1:0]   r_tag;
  logic             r_out_valid;
  logic             r_out_last;
  logic [width-1:0] r_out_data;
  widx_t            r_idx;
  logic             r_drop;
  logic [7:0]       r_drop_cnt;

  logic             w_capture;
  logic             w_xfer;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  quad_t            w_cap_quad;
  quad_t            w_head;
  quad_t            w_next;
  logic             w_empty;
  logic             w_has_next;
  logic             w_full;

  logic             w_valid_nxt;
  logic             w_last_nxt;
  logic [width-1:0] w_data_nxt;
  widx_t            w_idx_nxt;

  generate
    if (LAT == 1) begin : g_tag_short
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_tag <= '0;
        else      r_tag <= in_valid;
      end
    end else begin : g_tag_long
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_tag <= '0;
        else      r_tag <= {r_tag[LAT-2:0], in_valid};
      end
    end
  endgenerate

  assign w_capture  = r_tag[LAT-1];
  assign w_cap_quad = {minf, medl, medh, maxf};
  assign w_xfer     = r_out_valid & out_ready;
  assign w_pop      = w_xfer & (r_idx == 2'd3);
  // A pop in the same cycle frees the slot the capture needs.
  assign w_push     = w_capture & (~w_full | w_pop);
  assign w_drop     = w_capture & w_full & ~w_pop;

  sort4_quad_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst),
    .i_push     (w_push),
    .i_wdata    (w_cap_quad),
    .i_pop      (w_pop),
    .o_head     (w_head),
    .o_next     (w_next),
    .o_empty    (w_empty),
    .o_has_next (w_has_next),
    .o_full     (w_full)
  );

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_valid_nxt = r_out_valid;
    w_last_nxt  = r_out_last;
    w_data_nxt  = r_out_data;
    w_idx_nxt   = r_idx;
    if (!r_out_valid || out_ready) begin
      w_valid_nxt = 1'b0;
      w_idx_nxt   = '0;
      if (w_pop) begin
        // Roll straight into the following quad so back-to-back quads have no bubble.
        if (w_has_next) begin
          w_valid_nxt = 1'b1;
          w_data_nxt  = word_at(w_next, 2'd0);
        end
      end else if (w_xfer) begin
        w_valid_nxt = 1'b1;
        w_idx_nxt   = widx_t'(r_idx + 2'd1);
        w_data_nxt  = word_at(w_head, widx_t'(r_idx + 2'd1));
      end else if (!w_empty) begin
        w_valid_nxt = 1'b1;
        w_data_nxt  = word_at(w_head, 2'd0);
      end
      w_last_nxt = w_valid_nxt && (w_idx_nxt == 2'd3);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
      r_idx       <= '0;
      r_drop      <= 1'b0;
      r_drop_cnt  <= '0;
    end else begin
      r_out_valid <= w_valid_nxt;
      r_out_last  <= w_last_nxt;
      r_out_data  <= w_data_nxt;
      r_idx       <= w_idx_nxt;
      r_drop      <= w_drop;
      if (w_drop && (r_drop_cnt != 8'hFF)) r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign out_data  = r_out_data;
  assign full      = w_full;
  assign drop      = r_drop;
  assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_sort4_drain.sv
// Self-checking bench for sort4_drain: directed scenarios plus random traffic,
// all scored against a queue-based model of the quad buffer and word stream.
module tb_sort4_drain;

  localparam int W     = 32;
  localparam int LAT   = 5;
  localparam int DEPTH = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] maxf = '0, medh = '0, medl = '0, minf = '0;
  logic [W-1:0] out_data;
  logic         out_valid, out_last, full, drop;
  logic [7:0]   drop_cnt;

  sort4_drain #(.width(W), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst_n),
    .in_valid  (in_valid),
    .maxf      (maxf),
    .medh      (medh),
    .medl      (medl),
    .minf      (minf),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .full      (full),
    .drop      (drop),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Quads are packed {maxf, medh, medl, minf}; sched maps capture edge -> quad.
  logic [127:0] sched [int];
  logic [127:0] m_buf [$];
  int           m_idx;
  bit           m_pres;
  bit           m_drop;
  int           m_dcnt;

  localparam logic [127:0] QA = {32'd40, 32'd30, 32'd20, 32'd10};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] emit_word(input logic [127:0] q, input int k);
`ifdef SORT4_DRAIN_DESC_EN
    return q[32*(3-k) +: 32];
`else
    return q[32*k +: 32];
`endif
  endfunction

  task automatic model_clear();
    m_buf.delete();
    sched.delete();
    m_idx  = 0;
    m_pres = 1'b0;
    m_drop = 1'b0;
    m_dcnt = 0;
  endtask

  task automatic model_edge(input int e, input bit rdy);
    bit has_words;
    m_drop = 1'b0;
    if (m_pres && rdy) begin
      if (m_idx == 3) begin
        void'(m_buf.pop_front());
        m_idx = 0;
      end else begin
        m_idx++;
      end
    end
    has_words = (m_buf.size() > 0);
    if (sched.exists(e)) begin
      if (m_buf.size() < DEPTH) m_buf.push_back(sched[e]);
      else begin
        m_drop = 1'b1;
        if (m_dcnt < 255) m_dcnt++;
      end
      sched.delete(e);
    end
    m_pres = has_words;
  endtask

  task automatic check_model();
    check("out_valid", 32'(out_valid), 32'(m_pres));
    if (m_pres) begin
      check("out_data", out_data, emit_word(m_buf[0], m_idx));
      check("out_last", 32'(out_last), 32'(m_idx == 3));
    end
    check("full", 32'(full), 32'(m_buf.size() == DEPTH));
    check("drop", 32'(drop), 32'(m_drop));
    check("drop_cnt", 32'(drop_cnt), 32'(m_dcnt));
  endtask

  task automatic check_reset_outs(input string pfx);
    check({pfx, "_out_data"},  out_data, 32'd0);
    check({pfx, "_out_valid"}, 32'(out_valid), 32'd0);
    check({pfx, "_out_last"},  32'(out_last), 32'd0);
    check({pfx, "_full"},      32'(full), 32'd0);
    check({pfx, "_drop"},      32'(drop), 32'd0);
    check({pfx, "_drop_cnt"},  32'(drop_cnt), 32'd0);
  endtask

  // One clock: drive inputs for the next edge, advance the model, score outputs.
  task automatic step(input bit iv, input bit rdy, input logic [127:0] q_in);
    int e;
    e = cyc + 1;
    in_valid  = iv;
    out_ready = rdy;
    if (sched.exists(e)) {maxf, medh, medl, minf} = sched[e];
    else {maxf, medh, medl, minf} = {$urandom, $urandom, $urandom, $urandom};
    if (iv && rst_n)
      sched[e + LAT] = (q_in != '0) ? q_in : {$urandom, $urandom, $urandom, $urandom};
    @(posedge clk);
    cyc++;
    if (rst_n) model_edge(e, rdy);
    #1;
    check_model();
  endtask

  initial begin
    int first_k;
    int n_cnt;
    int guard;
    logic [31:0] first_w;
    logic [31:0] exp_first;

    model_clear();
    #1;
    check_reset_outs("rst");
    repeat (3) step(1'b0, 1'b0, '0);
    rst_n = 1'b1;
    repeat (2) step(1'b0, 1'b0, '0);

    // Single quad, ready held high: first word LAT+1 edges after in_valid.
`ifdef SORT4_DRAIN_DESC_EN
    exp_first = 32'd40;
`else
    exp_first = 32'd10;
`endif
    first_k = -1;
    first_w = '0;
    step(1'b1, 1'b1, QA);
    for (int k = 1; k <= 12; k++) begin
      step(1'b0, 1'b1, '0);
      if (out_valid && first_k < 0) begin
        first_k = k;
        first_w = out_data;
      end
    end
    check("single_latency", 32'(first_k), 32'(LAT + 1));
    check("single_first_word", first_w, exp_first);

    // Backpressure with ready pattern 1,0,0,1.
    n_cnt = 0;
    step(1'b1, 1'b1, QA);
    for (int k = 1; k <= 30; k++) begin
      bit rdy;
      rdy = ((k % 4) == 0) || ((k % 4) == 3);
      if (out_valid && rdy) n_cnt++;
      step(1'b0, rdy, '0);
    end
    check("bp_words", 32'(n_cnt), 32'd4);

    // Overflow: three captures with no drain.
    n_cnt = 0;
    for (int k = 0; k < LAT + 8; k++) begin
      step((k == 0) || (k == 2) || (k == 4), 1'b0, '0);
      if (drop) n_cnt++;
    end
    check("ovf_drop_pulses", 32'(n_cnt), 32'd1);
    check("ovf_drop_cnt", 32'(drop_cnt), 32'd1);
    check("ovf_full", 32'(full), 32'd1);
    n_cnt = 0;
    for (int k = 0; k < 14; k++) begin
      if (out_valid && out_last) n_cnt++;
      step(1'b0, 1'b1, '0);
    end
    check("ovf_drained_quads", 32'(n_cnt), 32'd2);

    // Pop/capture collision: capture lands on the word-3 transfer of a full buffer.
    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b0, '0);
    repeat (LAT + 2) step(1'b0, 1'b0, '0);
    check("coll_full_before", 32'(full), 32'd1);
    step(1'b1, 1'b0, '0);
    for (int k = 1; k <= 16; k++) step(1'b0, (k >= LAT - 3), '0);
    check("coll_drop_cnt", 32'(drop_cnt), 32'd1);
    check("coll_empty_after", 32'(out_valid), 32'd0);

    // Reset mid-stream: word 2 of a quad on the output, another quad buffered,
    // one more in flight in the tag line.
    step(1'b1, 1'b1, '0);
    step(1'b1, 1'b1, '0);
    for (int k = 2; k < 6; k++) step(1'b0, 1'b1, '0);
    step(1'b1, 1'b1, '0);
    guard = 0;
    while (!(m_pres && m_idx == 2 && m_buf.size() >= 2) && guard < 40) begin
      step(1'b0, 1'b1, '0);
      guard++;
    end
    check("midrst_reached", 32'(guard < 40), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    model_clear();
    #1;
    check_reset_outs("midrst");
    repeat (2) step(1'b0, 1'b1, '0);
    rst_n = 1'b1;
    repeat (LAT + 4) step(1'b0, 1'b1, '0);
    step(1'b1, 1'b1, QA);
    repeat (LAT + 6) step(1'b0, 1'b1, '0);

    // Random traffic, then drain.
    for (int k = 0; k < 3000; k++)
      step(($urandom_range(0, 2) == 0), ($urandom_range(0, 3) != 0), '0);
    repeat (40) step(1'b0, 1'b1, '0);
    check("final_idle", 32'(out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
